// File: rtl/program_loader.sv
`timescale 1ns/1ps
// Byte-stream loader for the core's instruction memory: parses a length-prefixed
// frame, writes each instruction, then releases the core and times its run.
module program_loader #(
  parameter int PC_BITS    = 9,
  parameter int INS_BITS   = 9,
  parameter int CYCLE_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_req,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [PC_BITS-1:0]    im_addr,
  output logic [INS_BITS-1:0]   im_wdata,
  output logic                  core_start,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CYCLE_BITS-1:0] run_cycles,
  output logic [2:0]            dbg_state
);

  // Handshake: a byte moves on every rising edge where in_valid and in_ready are
  // both high; in_valid may stall freely and the loader never drops in_ready mid-state.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    INS_LO = 3'd3,
    INS_HI = 3'd4,
    RUN    = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  localparam logic [16:0]      MAX_LEN = 17'(1) << PC_BITS;
  localparam logic [7:0]       HI_MASK = 8'(8'hFF << (INS_BITS - 8));
  localparam logic [PC_BITS:0] CNT_ONE = (PC_BITS + 1)'(1);
  localparam logic [CYCLE_BITS-1:0] CYC_ONE = CYCLE_BITS'(1);

  state_t              state, state_nxt;
  logic [7:0]          lo_byte;
  logic [PC_BITS:0]    len;
  logic [PC_BITS:0]    cnt;
  logic [PC_BITS:0]    cnt_inc;
  logic [16:0]         len_full;
  logic                xfer;
  logic                len_bad;
  logic                hi_bad;

  assign xfer      = in_valid & in_ready;
  assign len_full  = {1'b0, in_data, lo_byte};
  assign len_bad   = (len_full == 17'd0) || (len_full > MAX_LEN);
  assign hi_bad    = |(in_data & HI_MASK);
  assign cnt_inc   = cnt + CNT_ONE;
  assign im_addr   = cnt[PC_BITS-1:0];
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    im_we      = 1'b0;
    im_wdata   = '0;
    core_start = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        done  = (state == DONE);
        error = (state == ERROR);
        if (load_req) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = len_bad ? ERROR : INS_LO;
      end
      INS_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = INS_HI;
      end
      INS_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        im_wdata = {in_data[INS_BITS-9:0], lo_byte};
        if (xfer) begin
          if (hi_bad) begin
            state_nxt = ERROR;
          end else begin
            im_we     = 1'b1;
            state_nxt = (cnt_inc == len) ? RUN : INS_LO;
          end
        end
      end
      RUN: begin
        busy       = 1'b1;
        core_start = 1'b0;
        if (core_done) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lo_byte    <= '0;
      len        <= '0;
      cnt        <= '0;
      run_cycles <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE, ERROR: begin
          if (load_req) begin
            cnt        <= '0;
            run_cycles <= '0;
          end
        end
        LEN_LO, INS_LO: if (xfer) lo_byte <= in_data;
        LEN_HI: if (xfer) len <= len_full[PC_BITS:0];
        INS_HI: begin
          if (im_we) cnt <= cnt_inc;
          if (state_nxt == RUN) run_cycles <= '0;
        end
        RUN: begin
          // Saturates so a runaway program still reads as "at least this long".
          if (!core_done && (run_cycles != '1)) run_cycles <= run_cycles + CYC_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
// Self-checking bench for program_loader: drives length-prefixed frames and
// scoreboards every instruction-memory write against a queue of expected writes.
module tb_program_loader;

  localparam int PC_BITS    = 9;
  localparam int INS_BITS   = 9;
  localparam int CYCLE_BITS = 16;
  localparam int W          = PC_BITS + INS_BITS;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  load_req = 1'b0;
  logic                  in_valid = 1'b0;
  logic [7:0]            in_data = 8'h00;
  logic                  core_done = 1'b0;
  logic                  in_ready;
  logic                  im_we;
  logic [PC_BITS-1:0]    im_addr;
  logic [INS_BITS-1:0]   im_wdata;
  logic                  core_start;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [CYCLE_BITS-1:0] run_cycles;
  logic [2:0]            dbg_state;

  program_loader #(.PC_BITS(PC_BITS), .INS_BITS(INS_BITS), .CYCLE_BITS(CYCLE_BITS)) dut (
    .clock(clock), .reset_n(reset_n), .load_req(load_req),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_start(core_start), .core_done(core_done),
    .busy(busy), .done(done), .error(error),
    .run_cycles(run_cycles), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  logic [PC_BITS-1:0] last_addr = '0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  prog [0:511];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clock) begin
    if (reset_n && im_we === 1'b1) begin
      n_writes++;
      last_addr = im_addr;
      check("we_only_on_valid", {31'd0, in_valid}, 32'd1);
      check("write_queued", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("write", {14'd0, im_addr, im_wdata}, {14'd0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clock); #1;
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clock); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock); #1;
    end
    if (!acc) check("byte_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input int len_field, input int n_ins, input bit gap, input int req_idx);
    logic [15:0] w;
    pulse_load_req();
    send_byte(len_field[7:0], gap);
    send_byte(len_field[15:8], gap);
    for (int i = 0; i < n_ins; i++) begin
      w = prog[i];
      if (i == req_idx) begin
        pulse_load_req();
        @(negedge clock);
        check("load_req_ignored", {29'd0, dbg_state}, 32'd3);
        @(posedge clock); #1;
      end
      send_byte(w[7:0], gap);
      if (w[15:9] == 7'd0) exp_q.push_back({i[PC_BITS-1:0], w[8:0]});
      send_byte(w[15:8], gap);
      if (w[15:9] != 7'd0) break;
    end
  endtask

  task automatic finish_run_now();
    core_done = 1'b1;
    @(posedge clock); #1;
    core_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    check("watchdog", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    // reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_im_we", {31'd0, im_we}, 32'd0);
    check("rst_im_addr", {23'd0, im_addr}, 32'd0);
    check("rst_im_wdata", {23'd0, im_wdata}, 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // L=3, back-to-back bytes, core finishes after 5 run cycles
    prog[0] = 16'h0012; prog[1] = 16'h0134; prog[2] = 16'h00FF;
    load_frame(3, 3, 1'b0, -1);
    @(negedge clock);
    check("run_core_start", {31'd0, core_start}, 32'd0);
    check("run_state", {29'd0, dbg_state}, 32'd5);
    check("run_busy", {31'd0, busy}, 32'd1);
    check("writes_a", n_writes, 32'd3);
    repeat (5) @(posedge clock);
    #1;
    finish_run_now();
    @(negedge clock);
    check("done_a", {31'd0, done}, 32'd1);
    check("run_cycles_a", {16'd0, run_cycles}, 32'd5);
    check("done_core_start", {31'd0, core_start}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);

    // same frame with gaps, plus load_req during INS_LO; core_done on first RUN cycle
    load_frame(3, 3, 1'b1, 1);
    check("writes_b", n_writes, 32'd6);
    finish_run_now();
    @(negedge clock);
    check("done_b", {31'd0, done}, 32'd1);
    check("run_cycles_b", {16'd0, run_cycles}, 32'd0);

    // length errors
    load_frame(0, 0, 1'b0, -1);
    @(negedge clock);
    check("len0_error", {31'd0, error}, 32'd1);
    check("len0_core_start", {31'd0, core_start}, 32'd1);
    check("len0_done", {31'd0, done}, 32'd0);
    check("len0_writes", n_writes, 32'd6);
    load_frame(16'h0201, 0, 1'b0, -1);
    @(negedge clock);
    check("len201_error", {31'd0, error}, 32'd1);
    check("len201_state", {29'd0, dbg_state}, 32'd7);

    // bad high byte on 2nd instruction, then recovery
    prog[0] = 16'h00AB; prog[1] = 16'h0255; prog[2] = 16'h0001;
    load_frame(3, 3, 1'b0, -1);
    @(negedge clock);
    check("hibad_error", {31'd0, error}, 32'd1);
    check("hibad_writes", n_writes, 32'd7);
    check("hibad_queue", exp_q.size(), 32'd0);
    prog[1] = 16'h0155;
    load_frame(2, 2, 1'b0, -1);
    @(negedge clock);
    check("recover_state", {29'd0, dbg_state}, 32'd5);
    check("recover_writes", n_writes, 32'd9);
    #1 finish_run_now();
    @(negedge clock);
    check("recover_done", {31'd0, done}, 32'd1);

    // maximum length: 512 writes, then run without core_done until saturation
    for (int i = 0; i < 512; i++) prog[i] = {7'd0, 9'($urandom_range(0, 511))};
    load_frame(16'h0200, 512, 1'b0, -1);
    @(negedge clock);
    check("max_writes", n_writes, 32'd521);
    check("max_last_addr", {23'd0, last_addr}, 32'h1FF);
    check("max_state", {29'd0, dbg_state}, 32'd5);
    check("max_core_start", {31'd0, core_start}, 32'd0);
    repeat (70000) @(posedge clock);
    @(negedge clock);
    check("sat_run_cycles", {16'd0, run_cycles}, 32'hFFFF);
    check("sat_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstrun_state", {29'd0, dbg_state}, 32'd0);
    check("rstrun_core_start", {31'd0, core_start}, 32'd1);
    check("rstrun_busy", {31'd0, busy}, 32'd0);
    check("rstrun_run_cycles", {16'd0, run_cycles}, 32'd0);
    check("rstrun_done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // reset during an INS_HI stall
    pulse_load_req();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h77, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("stall_state", {29'd0, dbg_state}, 32'd4);
    check("stall_im_we", {31'd0, im_we}, 32'd0);
    @(posedge clock); #1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    #1 reset_n = 1'b0;
    #1;
    check("rsthi_im_we", {31'd0, im_we}, 32'd0);
    check("rsthi_state", {29'd0, dbg_state}, 32'd0);
    check("rsthi_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // final report
    check("queue_empty", exp_q.size(), 32'd0);
    check("total_writes", n_writes, 32'd521);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Host-side writer for the core's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles 9-bit instructions, and writes them to consecutive instruction-memory addresses starting at 0. It holds the core in start while loading, then releases it and waits for `done`. It reports the run length in cycles. It sits between the test/host interface and the core's `instructionmem` write port and `start`/`done` pins.

## Interface
- PC_BITS, 9, instruction address width; max program length 2^PC_BITS
- INS_BITS, 9, instruction width (9..16); bits [INS_BITS-1:8] carried in second byte
- CYCLE_BITS, 16, width of run-cycle counter
- clock  input  1  rising-edge clock, single domain
- reset_n  input  1  asynchronous active-low reset
- load_req  input  1  one-cycle request to begin a new load; honoured only in IDLE, DONE, ERROR
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
- im_we  output  1  instruction-memory write enable
- im_addr  output  PC_BITS  write address
- im_wdata  output  INS_BITS  write data
- core_start  output  1  core start; high holds core at start address, low lets it run
- core_done  input  1  core `done`
- busy  output  1  high in LEN_LO, LEN_HI, INS_LO, INS_HI, RUN
- done  output  1  high in DONE
- error  output  1  high in ERROR
- run_cycles  output  CYCLE_BITS  cycles spent in RUN before core_done, saturating

## Operation
- Frame format: length L as 16-bit little-endian (2 bytes), then L instructions. Each instruction is 2 bytes: low byte = bits[7:0], high byte bits[INS_BITS-9:0] = bits[INS_BITS-1:8].
- States: IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, RUN, DONE, ERROR.
- IDLE/DONE/ERROR + load_req -> LEN_LO. This clears the address counter. done, error and run_cycles are held until then.
- LEN_LO: transfer latches low length byte -> LEN_HI.
- LEN_HI: transfer forms L.
  - L==0 or L>2^PC_BITS -> ERROR.
  - Otherwise -> INS_LO.
- INS_LO: transfer latches low byte -> INS_HI.
- INS_HI: transfer with any in_data bit at or above (INS_BITS-8) set -> ERROR, and no write occurs.
  - Otherwise, in the same cycle: im_we=1, im_addr=counter, im_wdata={in_data[INS_BITS-9:0], low byte}. Counter then increments.
  - After the L-th write -> RUN. Otherwise -> INS_LO.
- in_ready = 1 exactly in LEN_LO, LEN_HI, INS_LO, INS_HI. A stalled in_valid leaves the state unchanged.
- core_start = 0 only in RUN. It is 1 in every other state, including reset.
- RUN: run_cycles clears on entry. It increments each RUN cycle with core_done=0 and saturates at all-ones. A cycle with core_done=1 -> DONE.
- core_done is ignored outside RUN. load_req is ignored in busy states.
- Counter arithmetic is PC_BITS+1 wide so L=2^PC_BITS is representable. im_addr never exceeds 2^PC_BITS-1.

## Timing
- Reset (async assert, sync release effect next edge) outputs:
  - state IDLE, in_ready 0, im_we 0, im_addr 0, im_wdata 0.
  - core_start 1, busy 0, done 0, error 0, run_cycles 0.
- im_we is combinational from the INS_HI transfer, the same cycle as the byte. im_addr/im_wdata are valid in that cycle.
- Best-case throughput: 1 byte/cycle, i.e. 1 instruction per 2 cycles.
- RUN entered the cycle after the last write. core_start falls on that edge.
- With core_done already high on the first RUN cycle: DONE next cycle, run_cycles=0.
- done/error assert the cycle after the deciding transfer or core_done sample.
- reset_n low mid-load or mid-run: immediate return to reset values. Memory contents are not cleared.

## Test plan
- Load L=3 (bytes 03 00, 12 00, 34 01, FF 00) with in_valid always high -> writes (0,0x012),(1,0x134),(2,0x0FF) on consecutive INS_HI cycles. core_start falls after the 3rd write. core_done raised 5 cycles later -> done=1, run_cycles=5.
- Same load with in_valid toggling every other cycle -> identical write sequence, no duplicate or dropped writes, im_we only on transfer cycles.
- Length errors: L=0 -> error=1, no writes, core_start stays 1. L=0x0201 -> error. L=0x0200 -> 512 writes, last at im_addr=0x1FF, then RUN.
- High byte 0x02 for the 2nd instruction -> exactly one write (addr 0), then error=1. A following load_req with a valid frame recovers.
- core_done never asserted for 70000 cycles with CYCLE_BITS=16 -> run_cycles saturates at 0xFFFF. reset_n pulse -> all outputs return to reset values.
- load_req pulsed during INS_LO -> ignored. reset_n asserted mid-INS_HI stall -> state IDLE, im_we 0 within the same cycle.
